// File: rtl/cic_comp_fir_if.sv
// Sample, coefficient and status bundle between the CIC decimator side and the compensation FIR.
// The master drives samples, coefficient writes and clr_ovr; the slave returns results and status.
interface cic_comp_fir_if #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int NTAPS = 16
);
  logic                     in_valid;
  logic [DW-1:0]            in_data;
  logic                     coef_we;
  logic [$clog2(NTAPS)-1:0] coef_addr;
  logic [CW-1:0]            coef_data;
  logic                     clr_ovr;
  logic                     out_valid;
  logic [OW-1:0]            out_data;
  logic                     busy;
  logic                     ovr;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data, clr_ovr,
    input  out_valid, out_data, busy, ovr
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data, clr_ovr,
    output out_valid, out_data, busy, ovr
  );
endinterface

// File: rtl/cic_comp_fir.sv
// Decimating CIC droop-compensation FIR, one shared multiplier, out_valid NTAPS+1 edges after trigger.
// Inputs are never stalled; a trigger arriving while busy is dropped and flagged on sticky ovr.
module cic_comp_fir #(
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int NTAPS = 16,
  parameter int DECIM = 2,
  parameter int BUF   = 32
) (
  input  logic          CLK,
  input  logic          RST,
  cic_comp_fir_if.slave io
);
  localparam int PW  = $clog2(BUF);
  localparam int KW  = $clog2(NTAPS);
  localparam int AW  = DW + CW + KW;
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [NTAPS*CW-1:0] H_RST = (NTAPS*CW)'({1'b0, {(CW-1){1'b1}}});
  localparam logic signed [AW-1:0] OMAX  = (AW'(1) <<< (OW-1)) - AW'(1);
  localparam logic signed [AW-1:0] OMIN  = -(AW'(1) <<< (OW-1));
  localparam logic signed [AW-1:0] RHALF = AW'(1) <<< (CW-2);

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PHW-1:0]             phase_q, phase_d;
  logic [PW-1:0]              base_q, base_d;
  logic [KW-1:0]              k_q, k_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic                       out_valid_q, out_valid_d;
  logic [OW-1:0]              out_data_q, out_data_d;
  logic                       ovr_q, ovr_d;
  logic [BUF-1:0][DW-1:0]     buf_q, buf_d;
  logic [NTAPS-1:0][CW-1:0]   h_q, h_d;

  logic                       busy;
  logic                       trig;
  logic [PW-1:0]              rd_idx;
  logic signed [DW+CW-1:0]    prod;
  logic signed [AW-1:0]       rnd_sum;
  logic signed [AW-1:0]       rnd_shr;
  logic [OW-1:0]              sat;

  assign busy    = (state_q != IDLE);
  assign trig    = io.in_valid && (phase_q == PHW'(DECIM-1));
  // base is the newest sample; older taps walk backwards through the ring
  assign rd_idx  = base_q - PW'(k_q);
  assign prod    = $signed(buf_q[rd_idx]) * $signed(h_q[k_q]);
  assign rnd_sum = acc_q + RHALF;
  assign rnd_shr = rnd_sum >>> (CW-1);
  assign sat     = (rnd_shr > OMAX) ? OMAX[OW-1:0] :
                   (rnd_shr < OMIN) ? OMIN[OW-1:0] : rnd_shr[OW-1:0];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    phase_d     = phase_q;
    base_d      = base_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    ovr_d       = io.clr_ovr ? 1'b0 : ovr_q;
    buf_d       = buf_q;
    h_d         = h_q;

    if (io.in_valid) begin
      buf_d[wr_ptr_q] = io.in_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      phase_d         = (phase_q == PHW'(DECIM-1)) ? '0 : phase_q + PHW'(1);
    end

    // coefficient writes only land while idle, so a running MAC sees a stable set
    if (io.coef_we && !busy) begin
      h_d[io.coef_addr] = io.coef_data;
    end

    case (state_q)
      IDLE: begin
        if (trig) begin
          base_d  = wr_ptr_q;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{KW{prod[DW+CW-1]}}, prod};
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NTAPS-1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_data_d  = sat;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (trig && busy) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      phase_q     <= '0;
      base_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovr_q       <= 1'b0;
      buf_q       <= '0;
      h_q         <= H_RST;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      phase_q     <= phase_d;
      base_q      <= base_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovr_q       <= ovr_d;
      buf_q       <= buf_d;
      h_q         <= h_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.busy      = busy;
  assign io.ovr       = ovr_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: directed and random stimulus against a sum-of-products reference,
// results matched by a scoreboard queue that also checks the output edge number.
module tb_cic_comp_fir;
  localparam int DW = 16, CW = 16, OW = 16, NTAPS = 16, DECIM = 2, BUF = 32;
  localparam int LAT = NTAPS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cic_comp_fir_if #(.DW(DW), .CW(CW), .OW(OW), .NTAPS(NTAPS)) ifc ();

  cic_comp_fir #(
    .DW(DW), .CW(CW), .OW(OW), .NTAPS(NTAPS), .DECIM(DECIM), .BUF(BUF)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .io (ifc)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // reference model state
  int h_m [NTAPS];
  int hist[$];
  int phase_m;
  int last_acc;
  bit ovr_m;
  int exp_q[$];
  int exp_e[$];

  function automatic void chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, req, edge_n);
    end
  endfunction

  function automatic int s16(int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NTAPS; k++) h_m[k] = 0;
    h_m[0]   = 32767;
    hist.delete();
    phase_m  = 0;
    last_acc = -1000;
    ovr_m    = 1'b0;
    exp_q.delete();
    exp_e.delete();
  endfunction

  // y[n] = sat(round(sum_k h[k]*x[n-k] / 2^15)), x before reset is zero
  function automatic int ref_out();
    longint acc = 0;
    int n = hist.size();
    for (int k = 0; k < NTAPS; k++) begin
      if (n - 1 - k >= 0) acc += longint'(h_m[k]) * longint'(hist[n-1-k]);
    end
    acc = (acc + (longint'(1) << (CW-2))) >>> (CW-1);
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  // effect of the inputs presented now, taken at edge e
  function automatic void model_edge(int e, bit v, int d, bit we, int a, int cd, bit clr);
    bit bsy = (e - last_acc >= 1) && (e - last_acc <= NTAPS + 1);
    if (we && !bsy) h_m[a] = s16(cd);
    if (clr) ovr_m = 1'b0;
    if (v) begin
      hist.push_back(s16(d));
      if (phase_m == DECIM - 1) begin
        if (bsy) ovr_m = 1'b1;
        else begin
          last_acc = e;
          exp_q.push_back(ref_out());
          exp_e.push_back(e + LAT);
        end
      end
      phase_m = (phase_m + 1) % DECIM;
    end
  endfunction

  task automatic cyc(input bit v, input int d, input bit we = 0, input int a = 0,
                     input int cd = 0, input bit clr = 0);
    ifc.in_valid  = v;
    ifc.in_data   = d[DW-1:0];
    ifc.coef_we   = we;
    ifc.coef_addr = a[$clog2(NTAPS)-1:0];
    ifc.coef_data = cd[CW-1:0];
    ifc.clr_ovr   = clr;
    model_edge(edge_n + 1, v, d, we, a, cd, clr);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.coef_we  = 1'b0;
    ifc.clr_ovr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0);
  endtask

  task automatic feed(input int d, input int gap);
    cyc(1, d);
    idle(gap - 1);
  endtask

  task automatic load_all(input int c);
    for (int k = 0; k < NTAPS; k++) cyc(0, 0, 1, k, c);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && ifc.out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got data %0d at edge %0d, want no output", s16(int'(ifc.out_data)), edge_n);
      end else begin
        chk("out_data", s16(int'(ifc.out_data)), exp_q.pop_front());
        chk("out_edge", edge_n, exp_e.pop_front());
      end
    end
  end

  initial begin
    ifc.in_valid = 0; ifc.in_data = 0; ifc.coef_we = 0;
    ifc.coef_addr = 0; ifc.coef_data = 0; ifc.clr_ovr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_data", ifc.out_data, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_ovr", ifc.ovr, 0);

    // 1: default pass-through
    repeat (8) feed(16'h1234, 40);
    chk("t1_ovr", ifc.ovr, 0);

    // 2: flat averaging taps with DC input
    load_all(16'h0800);
    repeat (24) feed(1000, 10);

    // 3: saturation both ways
    load_all(16'h7FFF);
    repeat (18) feed(16'h7FFF, 10);
    repeat (18) feed(16'h8000, 10);

    // 4: impulse response with ramp taps
    for (int k = 0; k < NTAPS; k++) cyc(0, 0, 1, k, k * 16'h0100);
    repeat (16) feed(0, 10);
    feed(16'h4000, 10);
    repeat (20) feed(0, 10);

    // 5: overrun, clear and ignored coefficient write
    while (phase_m != 0) feed(0, 10);
    idle(20);
    cyc(1, 100); cyc(0, 0);
    cyc(1, 200); cyc(0, 0);
    cyc(1, 300); cyc(0, 0);
    cyc(1, 400);
    chk("t5_ovr_set", ifc.ovr, 1);
    chk("t5_busy", ifc.busy, 1);
    cyc(0, 0, 1, 0, 16'h1000);
    idle(20);
    chk("t5_ovr_held", ifc.ovr, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_ovr_clr", ifc.ovr, 0);
    repeat (4) feed(16'h0321, 10);

    // 6: reset during MAC
    while (phase_m != 0) feed(0, 10);
    idle(20);
    cyc(1, 16'h0555);
    cyc(1, 16'h0666);
    idle(8);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_busy_rst", ifc.busy, 0);
    chk("t6_valid_rst", ifc.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy_after", ifc.busy, 0);
    repeat (DECIM) feed(16'h0ABC, 20);
    chk("t6_queue_drained", exp_q.size(), 0);

    // random coefficients and samples, triggers kept far enough apart to avoid overrun
    for (int i = 0; i < 60; i++) begin
      int gap = $urandom_range(8, 11);
      for (int j = 0; j < gap; j++) begin
        bit we = ($urandom_range(0, 3) == 0);
        cyc(0, 0, we, $urandom_range(0, NTAPS-1), $urandom_range(0, 65535), ($urandom_range(0, 7) == 0));
      end
      cyc(1, $urandom_range(0, 65535), ($urandom_range(0, 3) == 0),
          $urandom_range(0, NTAPS-1), $urandom_range(0, 65535));
    end
    idle(30);
    chk("rand_ovr", ifc.ovr, ovr_m);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
